// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM line
// in clk50m cycles. Results update once per PWM period with a one-cycle
// valid strobe; ovf flags a period longer than the counter can hold or a
// constant input level (lvl then tells 0 % from 100 %).
module pwm_capture #(
   parameter int W = 8
) (
   input  logic         clk50m,
   input  logic         rst,
   input  logic         en,
   input  logic         pwm_in,
   output logic [W-1:0] per,
   output logic [W-1:0] hi,
   output logic         valid,
   output logic         ovf,
   output logic         lvl
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = W'(1);

   typedef enum logic {ARM, MEAS} state_t;

   state_t       state;
   logic         s1;
   logic         s2;
   logic         s3;
   logic         rise;
   logic [W-1:0] per_cnt;
   logic [W-1:0] hi_cnt;

   // Two-flop synchronizer on the asynchronous input, plus a history flop
   // so a rising edge can be detected on the synchronized level.
   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= pwm_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
   assign lvl  = s2;

   // Measurement FSM: arm on the first edge, then count period and high
   // time between consecutive rising edges; give up and re-arm when the
   // period counter reaches its maximum without seeing an edge.
   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         state   <= ARM;
         per_cnt <= '0;
         hi_cnt  <= '0;
         per     <= '0;
         hi      <= '0;
         valid   <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (!en) begin
            // Disabled: results hold, the next enable needs a fresh arm edge.
            state <= ARM;
            ovf   <= 1'b0;
         end else begin
            case (state)
               ARM: begin
                  // The cycle carrying the edge is counted as the first
                  // cycle of the period and of the high phase.
                  if (rise) begin
                     state   <= MEAS;
                     per_cnt <= CNT_ONE;
                     hi_cnt  <= CNT_ONE;
                  end
               end
               MEAS: begin
                  if (rise) begin
                     per     <= per_cnt;
                     hi      <= hi_cnt;
                     valid   <= 1'b1;
                     ovf     <= 1'b0;
                     per_cnt <= CNT_ONE;
                     hi_cnt  <= CNT_ONE;
                  end else if (per_cnt == CNT_MAX) begin
                     // No edge in range: flag it and wait for a new arm
                     // edge; the last good result stays on per/hi.
                     ovf   <= 1'b1;
                     state <= ARM;
                  end else begin
                     // hi_cnt never exceeds per_cnt, so it cannot wrap.
                     per_cnt <= per_cnt + CNT_ONE;
                     if (s2) begin
                        hi_cnt <= hi_cnt + CNT_ONE;
                     end
                  end
               end
               default: state <= ARM;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and randomized PWM stimulus for pwm_capture,
// compared every cycle against a timestamp-based reference model.
module tb_pwm_capture;

   localparam int W    = 8;
   localparam int MAXC = 255;
   localparam int HIST = 65536;

   logic         clk50m = 1'b0;
   logic         rst;
   logic         en;
   logic         pwm_in;
   logic [W-1:0] per;
   logic [W-1:0] hi;
   logic         valid;
   logic         ovf;
   logic         lvl;

   int n_checks = 0;
   int n_errors = 0;

   pwm_capture #(.W(W)) dut (
      .clk50m (clk50m),
      .rst    (rst),
      .en     (en),
      .pwm_in (pwm_in),
      .per    (per),
      .hi     (hi),
      .valid  (valid),
      .ovf    (ovf),
      .lvl    (lvl)
   );

   always #5 clk50m = ~clk50m;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: remembers every sampled input level since reset and
   // derives results from the sample indices of rising edges. A rise seen
   // in sample n is acted on two clocks later (synchronizer depth), using
   // the enable present on that later clock.
   bit x_hist [HIST];
   int m_idx;
   int mn;
   bit mr;
   bit armed;
   int last_rise;
   bit e_valid;
   bit e_ovf;
   bit e_lvl;
   int e_per;
   int e_hi;

   function automatic bit xs(input int k);
      return (k >= 1) ? x_hist[k] : 1'b0;
   endfunction

   always @(posedge clk50m or posedge rst) begin
      if (rst) begin
         m_idx     = 0;
         armed     = 1'b0;
         last_rise = 0;
         e_valid   = 1'b0;
         e_ovf     = 1'b0;
         e_lvl     = 1'b0;
         e_per     = 0;
         e_hi      = 0;
      end else begin
         m_idx++;
         if (m_idx >= HIST) begin
            $display("FAIL model_history got %0d expected below %0d", m_idx, HIST);
            $fatal(1);
         end
         x_hist[m_idx] = pwm_in;
         mn = m_idx - 2;
         mr = xs(mn) && !xs(mn - 1);
         e_valid = 1'b0;
         if (!en) begin
            armed = 1'b0;
            e_ovf = 1'b0;
         end else if (!armed) begin
            if (mr) begin
               armed     = 1'b1;
               last_rise = mn;
            end
         end else if (mr) begin
            e_per = mn - last_rise;
            e_hi  = 0;
            for (int k = last_rise; k < mn; k++) e_hi += int'(xs(k));
            e_valid   = 1'b1;
            e_ovf     = 1'b0;
            last_rise = mn;
         end else if (mn - last_rise == MAXC) begin
            e_ovf = 1'b1;
            armed = 1'b0;
         end
         e_lvl = xs(m_idx - 1);
      end
   end

   // Cycle-by-cycle comparison on the inactive clock edge.
   bit chk_on = 1'b0;
   int valid_cnt = 0;

   always @(negedge clk50m) begin
      if (chk_on && !rst) begin
         check_val("valid", valid, e_valid);
         check_val("ovf", ovf, e_ovf);
         check_val("lvl", lvl, e_lvl);
         check_val("per", per, e_per);
         check_val("hi", hi, e_hi);
         if (valid) valid_cnt++;
      end
   end

   task automatic drive_pwm(input int h, input int l, input int reps, input int drop_pct);
      for (int r = 0; r < reps; r++) begin
         for (int c = 0; c < h + l; c++) begin
            @(negedge clk50m);
            pwm_in = (c < h);
            en = ($urandom_range(0, 99) < drop_pct) ? 1'b0 : 1'b1;
         end
      end
   endtask

   task automatic hold_lvl(input logic v, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk50m);
         pwm_in = v;
         en = 1'b1;
      end
   endtask

   int v0;
   int rh;
   int rl;
   int rr;
   int rp;

   initial begin
      rst    = 1'b1;
      en     = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk50m);
      check_val("rst_per", per, 0);
      check_val("rst_hi", hi, 0);
      check_val("rst_valid", valid, 0);
      check_val("rst_ovf", ovf, 0);
      check_val("rst_lvl", lvl, 0);
      rst    = 1'b0;
      chk_on = 1'b1;
      en     = 1'b1;

      // 7 high / 13 low: first rise only arms
      v0 = valid_cnt;
      drive_pwm(7, 13, 5, 0);
      check_val("basic_nvalid", valid_cnt - v0, 4);
      check_val("basic_per", per, 20);
      check_val("basic_hi", hi, 7);

      // shortest period
      drive_pwm(1, 1, 20, 0);
      check_val("min_per", per, 2);
      check_val("min_hi", hi, 1);

      // longest period
      drive_pwm(254, 1, 3, 0);
      check_val("max_per", per, 255);
      check_val("max_hi", hi, 254);
      check_val("max_ovf", ovf, 0);

      // constant low, then constant high
      hold_lvl(1'b0, 300);
      check_val("low_ovf", ovf, 1);
      check_val("low_lvl", lvl, 0);
      check_val("low_per", per, 255);
      check_val("low_hi", hi, 254);
      hold_lvl(1'b1, 300);
      check_val("high_ovf", ovf, 1);
      check_val("high_lvl", lvl, 1);
      check_val("high_per", per, 255);

      // restart after overflow: one re-arm edge, then results
      hold_lvl(1'b0, 5);
      v0 = valid_cnt;
      drive_pwm(10, 30, 3, 0);
      check_val("restart_nvalid", valid_cnt - v0, 2);
      check_val("restart_per", per, 40);
      check_val("restart_hi", hi, 10);
      check_val("restart_ovf", ovf, 0);

      // enable dropped for 5 clocks inside a high phase
      drive_pwm(7, 13, 3, 0);
      v0 = valid_cnt;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk50m);
         pwm_in = (c < 7);
         en = !(c >= 1 && c < 6);
      end
      check_val("endrop_nvalid", valid_cnt - v0, 0);
      v0 = valid_cnt;
      drive_pwm(7, 13, 3, 0);
      check_val("reen_nvalid", valid_cnt - v0, 2);
      check_val("reen_per", per, 20);
      check_val("reen_hi", hi, 7);

      // asynchronous reset while counting
      drive_pwm(7, 13, 1, 0);
      drive_pwm(5, 0, 1, 0);
      @(posedge clk50m);
      #2 rst = 1'b1;
      #1;
      check_val("arst_per", per, 0);
      check_val("arst_hi", hi, 0);
      check_val("arst_valid", valid, 0);
      check_val("arst_ovf", ovf, 0);
      check_val("arst_lvl", lvl, 0);
      @(negedge clk50m);
      @(negedge clk50m);
      rst = 1'b0;
      v0 = valid_cnt;
      drive_pwm(7, 13, 3, 0);
      check_val("arst_nvalid", valid_cnt - v0, 2);
      check_val("arst_per2", per, 20);
      check_val("arst_hi2", hi, 7);

      // period change on the fly
      drive_pwm(7, 13, 3, 0);
      drive_pwm(4, 5, 4, 0);
      check_val("chg_per", per, 9);
      check_val("chg_hi", hi, 4);

      // randomized periods, occasional overlong lows and enable glitches
      for (int it = 0; it < 40; it++) begin
         rh = $urandom_range(1, 60);
         rl = $urandom_range(1, 60);
         if ($urandom_range(0, 9) == 0) rl = $urandom_range(200, 300);
         rr = $urandom_range(1, 4);
         rp = ($urandom_range(0, 3) == 0) ? 3 : 0;
         drive_pwm(rh, rl, rr, rp);
      end
      hold_lvl(1'b0, 5);

      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM measurement block: samples an external, asynchronous PWM line and reports the period and high time in `clk50m` cycles. It is the receive-side counterpart of `counter_pwm`. It sits between a pin or another block's `pwm` output and any logic that needs the duty cycle as numbers. Values update once per PWM period, with a one-cycle `valid` strobe. Out-of-range periods and constant levels (0 % / 100 %) are flagged through `ovf`.

## Interface
- `W`, default 8: counter and result width. The maximum measurable period is 2^W−1 clocks.
- `clk50m`  in  1  system clock. One clock only. Reset is asynchronous and active-high.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  measurement enable, synchronous.
- `pwm_in`  in  1  PWM input, asynchronous to `clk50m`.
- `per`  out  W  last measured period, in clocks (rising edge to rising edge).
- `hi`  out  W  last measured high time, in clocks.
- `valid`  out  1  one-cycle strobe when `per`/`hi` update.
- `ovf`  out  1  no rising edge seen within 2^W−1 clocks. Sticky until the next `valid`.
- `lvl`  out  1  synchronized input level (`s2`). Tells 0 % from 100 % when `ovf` = 1.

## Operation
- **Input path**
  - 2-FF synchronizer `s1` → `s2`, plus history register `s3`.
  - `rise` = `s2` & ~`s3`, combinational.
- **States**
  - ARM: wait for the first `rise`. No result is produced.
  - MEAS: count.
- **Transitions**
  - ARM→MEAS on `rise`. `per_cnt` ← 1, `hi_cnt` ← 1, no `valid`.
  - MEAS, `rise`:
    - `per` ← `per_cnt`, `hi` ← `hi_cnt`, `valid` ← 1, `ovf` ← 0.
    - `per_cnt` ← 1, `hi_cnt` ← 1. Stay in MEAS.
  - MEAS, no `rise`, `per_cnt` < 2^W−1:
    - `per_cnt` += 1.
    - `hi_cnt` += 1 if `s2` = 1, else hold.
  - MEAS, no `rise`, `per_cnt` = 2^W−1:
    - `ovf` ← 1, go to ARM.
    - `per`/`hi` hold their last values.
  - The next edge after an overflow only re-arms. The first `valid` after an overflow comes one full period later.
- **Enable**
  - `en` = 0 forces ARM, clears `ovf`, holds `per`/`hi`, keeps `valid` = 0.
  - The synchronizer keeps running, so `lvl` stays live.
  - After `en` rises, the first `valid` needs two input rising edges.
- **Width rules**
  - `hi_cnt` ≤ `per_cnt` always, so `hi_cnt` needs no separate saturation.
  - `hi` = `per` means the line was high the whole period, which cannot happen with a real rising edge. In practice `hi` ≤ `per`−1.
  - The minimum reportable period is 2 (pattern 1,0). It gives `per` = 2, `hi` = 1.
- **Reset** (any time, including mid-period)
  - `per` = 0, `hi` = 0, `valid` = 0, `ovf` = 0, `lvl` = 0.
  - `s1`/`s2`/`s3` = 0, state = ARM, counters = 0.

## Timing
- Edge A is the `clk50m` edge that first samples `pwm_in` = 1 into `s1`.
  - `s2` = 1 after A+1.
  - `rise` is high during the cycle after A+1.
  - Result registers update at A+2.
  - `valid` is high for exactly the cycle after A+2.
- Latency from input edge to `valid` is therefore 2 clocks, plus up to 1 clock of synchronizer uncertainty.
- `valid` is never high in two consecutive cycles. The minimum spacing equals the measured period, which is ≥ 2.
- `ovf` rises 2^W−1 clocks after the last counted rise. It falls together with the next `valid`, or when `en` = 0.
- All outputs are registered. `per` and `hi` are stable between `valid` strobes.

## Test plan
- `rst` = 1, then released. Drive `pwm_in` high 7 / low 13 repeatedly with `en` = 1. Required:
  - The first rise produces no `valid`.
  - Every later rise gives `valid` with `per` = 20, `hi` = 7.
  - Each `valid` occurs 2 clocks after the sampled edge.
- Extremes, W = 8:
  - 1-high / 1-low → `per` = 2, `hi` = 1, `valid` every other cycle.
  - Period 255 with high 254 → `per` = 255, `hi` = 254, `ovf` = 0.
- Constant levels:
  - Hold `pwm_in` = 0 after a valid measurement → `ovf` = 1 exactly 255 clocks after the last rise, `lvl` = 0, `per`/`hi` unchanged.
  - Repeat with `pwm_in` = 1 → `ovf` = 1, `lvl` = 1.
  - Then restart 10/30 PWM → the first rise gives no `valid`. The second gives `per` = 40, `hi` = 10, and `ovf` drops in the same cycle.
- `en` drop mid-period:
  - Deassert `en` for 5 clocks in the middle of a high phase → `valid` stays 0, `per`/`hi` hold.
  - After re-enable, two rises are needed, then correct values.
- Reset mid-operation: assert `rst` asynchronously between clock edges during counting → all outputs go 0 immediately. After release, behaviour matches a fresh start.
- Period change on the fly: switch from 20/7 to 9/4 → the first `valid` after the switch reports `per` = 20 or a mixed period as defined by the edge positions. From the next period on, `per` = 9, `hi` = 4.
